// File: rtl/fetch_stage_sequencer.sv
// IF-stage PC sequencer: drives a variable-latency instruction memory over req/ready and
// produces the IF/ID pipeline register, with a one-entry skid buffer and redirect/discard handling.
module fetch_stage_sequencer #(
  parameter int                 ADDR_W    = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               killF,
  input  logic [1:0]         PCSrc,
  input  logic               PCsrcJType,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [ADDR_W-1:0]  for_target,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic [ADDR_W-1:0]  ret_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               IFID_valid,
  output logic [INSTR_W-1:0] IFID_instr,
  output logic [ADDR_W-1:0]  IFID_pc,
  output logic [ADDR_W-1:0]  IFID_pcplus,
  output logic [1:0]         state_dbg
);

  // Handshake: a fetch is accepted on any rising edge where imem_req=1 and imem_ready=1;
  // imem_addr is held constant from the first cycle of imem_req until that edge.
  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   pc, pc_d;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   redirect_pc;
  logic                started;
  logic                skid_valid, skid_valid_d;
  logic [INSTR_W-1:0]  skid_instr, skid_instr_d;
  logic [ADDR_W-1:0]   skid_pc, skid_pc_d;
  logic [ADDR_W-1:0]   discard_addr, discard_addr_d;
  logic                ifid_valid_d;
  logic [INSTR_W-1:0]  ifid_instr_d;
  logic [ADDR_W-1:0]   ifid_pc_d;
  logic [ADDR_W-1:0]   ifid_pcplus_d;

  assign pc_inc    = pc + ADDR_W'(1);
  assign state_dbg = state;

  // started keeps imem_req low during the first cycle after reset release.
  assign imem_req  = started && (state != ST_HOLD);
  assign imem_addr = (state == ST_DISCARD) ? discard_addr : pc;

  always_comb begin
    case (PCSrc)
      2'b01:   redirect_pc = branch_target;
      2'b10:   redirect_pc = for_target;
      2'b11:   redirect_pc = PCsrcJType ? ret_addr : jump_target;
      default: redirect_pc = pc_inc;
    endcase
  end

  always_comb begin
    state_d        = state;
    pc_d           = pc;
    skid_valid_d   = skid_valid;
    skid_instr_d   = skid_instr;
    skid_pc_d      = skid_pc;
    discard_addr_d = discard_addr;
    ifid_valid_d   = IFID_valid;
    ifid_instr_d   = IFID_instr;
    ifid_pc_d      = IFID_pc;
    ifid_pcplus_d  = IFID_pcplus;

    case (state)
      ST_FETCH: begin
        if (started) begin
          if (stall) begin
            // IF/ID is frozen; a completing fetch parks in the skid buffer.
            if (imem_ready) begin
              skid_valid_d = 1'b1;
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc;
              pc_d         = pc_inc;
              state_d      = ST_HOLD;
            end
          end else if (killF) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            skid_valid_d = 1'b0;
            pc_d         = redirect_pc;
            if (!imem_ready) begin
              discard_addr_d = pc;
              state_d        = ST_DISCARD;
            end
          end else if (imem_ready) begin
            ifid_valid_d  = 1'b1;
            ifid_instr_d  = imem_rdata;
            ifid_pc_d     = pc;
            ifid_pcplus_d = pc_inc;
            pc_d          = pc_inc;
          end else begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
          end
        end
      end

      ST_HOLD: begin
        if (!stall) begin
          skid_valid_d = 1'b0;
          state_d      = ST_FETCH;
          if (killF) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            pc_d         = redirect_pc;
          end else begin
            ifid_valid_d  = 1'b1;
            ifid_instr_d  = skid_instr;
            ifid_pc_d     = skid_pc;
            ifid_pcplus_d = skid_pc + ADDR_W'(1);
          end
        end
      end

      ST_DISCARD: begin
        // The stale request must still complete; its data is thrown away.
        if (imem_ready) begin
          state_d = ST_FETCH;
        end
        if (!stall) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          if (killF) begin
            pc_d = redirect_pc;
          end
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_FETCH;
      pc           <= RESET_PC;
      started      <= 1'b0;
      skid_valid   <= 1'b0;
      skid_instr   <= NOP_INSTR;
      skid_pc      <= '0;
      discard_addr <= '0;
      IFID_valid   <= 1'b0;
      IFID_instr   <= NOP_INSTR;
      IFID_pc      <= '0;
      IFID_pcplus  <= '0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      started      <= 1'b1;
      skid_valid   <= skid_valid_d;
      skid_instr   <= skid_instr_d;
      skid_pc      <= skid_pc_d;
      discard_addr <= discard_addr_d;
      IFID_valid   <= ifid_valid_d;
      IFID_instr   <= ifid_instr_d;
      IFID_pc      <= ifid_pc_d;
      IFID_pcplus  <= ifid_pcplus_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage_sequencer.sv
// Bench for fetch_stage_sequencer: random-latency memory model, directed and random
// stall/redirect stimulus, scoreboard of the expected instruction stream.
module tb_fetch_stage_sequencer;

  localparam logic [15:0] NOP = 16'h0000;
  localparam logic [1:0]  ST_HOLD_DBG    = 2'd1;
  localparam logic [1:0]  ST_DISCARD_DBG = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        killF;
  logic [1:0]  PCSrc;
  logic        PCsrcJType;
  logic [15:0] branch_target, for_target, jump_target, ret_addr;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        IFID_valid;
  logic [15:0] IFID_instr, IFID_pc, IFID_pcplus;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int n_deliv = 0;
  int lat_min = 0;
  int lat_max = 0;
  logic [47:0] exp_q[$];

  fetch_stage_sequencer #(
    .ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .killF(killF),
    .PCSrc(PCSrc), .PCsrcJType(PCsrcJType),
    .branch_target(branch_target), .for_target(for_target),
    .jump_target(jump_target), .ret_addr(ret_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .IFID_valid(IFID_valid), .IFID_instr(IFID_instr),
    .IFID_pc(IFID_pc), .IFID_pcplus(IFID_pcplus),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a + 16'h0100;
  endfunction

  function automatic logic [47:0] entry(input logic [15:0] pc);
    logic [15:0] nxt;
    nxt = pc + 16'd1;
    return {mem_fn(pc), pc, nxt};
  endfunction

  // Program flow restarts at pc: the next instructions delivered are pc, pc+1, ...
  task automatic restart_model(input logic [15:0] pc);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(entry(pc + 16'(i)));
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory driver ----------------
  int          wait_cnt = -1;
  logic [15:0] req_addr;

  always @(negedge clk) begin
    if (!reset || !imem_req) begin
      imem_ready = 1'b0;
      wait_cnt   = -1;
    end else begin
      if (wait_cnt < 0) begin
        wait_cnt = int'($urandom_range(lat_max, lat_min));
        req_addr = imem_addr;
      end else begin
        check("imem_addr_stable", 64'(imem_addr), 64'(req_addr));
      end
      if (wait_cnt == 0) begin
        imem_ready = 1'b1;
        imem_rdata = mem_fn(imem_addr);
        wait_cnt   = -1;
      end else begin
        imem_ready = 1'b0;
        imem_rdata = 16'($urandom);
        wait_cnt--;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        mon_stall, mon_rst;
  logic [48:0] prev_ifid = '0;
  logic [47:0] exp_e, tail_e;

  always @(posedge clk) begin
    mon_stall = stall;
    mon_rst   = reset;
    #1;
    if (mon_rst && reset) begin
      if (mon_stall) begin
        check("ifid_hold", 64'({IFID_valid, IFID_instr, IFID_pc, IFID_pcplus}), 64'(prev_ifid));
      end else if (IFID_valid) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          check("ifid_unexpected", 64'({IFID_instr, IFID_pc, IFID_pcplus}), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_e = exp_q.pop_front();
          check("ifid_entry", 64'({IFID_instr, IFID_pc, IFID_pcplus}), 64'(exp_e));
          while (exp_q.size() < 32) begin
            tail_e = (exp_q.size() == 0) ? exp_e : exp_q[exp_q.size()-1];
            exp_q.push_back(entry(tail_e[31:16] + 16'd1));
          end
        end
      end else begin
        check("bubble_instr", 64'(IFID_instr), 64'(NOP));
      end
    end
    prev_ifid = {IFID_valid, IFID_instr, IFID_pc, IFID_pcplus};
  end

  // ---------------- driver tasks ----------------
  task automatic do_redirect(input logic [1:0] src, input logic j, input logic [15:0] tgt);
    PCSrc = src;
    PCsrcJType = j;
    branch_target = 16'($urandom);
    for_target    = 16'($urandom);
    jump_target   = 16'($urandom);
    ret_addr      = 16'($urandom);
    case (src)
      2'b01:   branch_target = tgt;
      2'b10:   for_target = tgt;
      default: if (j) ret_addr = tgt; else jump_target = tgt;
    endcase
    stall = 1'b0;
    killF = 1'b1;
    restart_model(tgt);
    @(negedge clk);
    killF = 1'b0;
    PCSrc = 2'b00;
  endtask

  task automatic wait_addr(input logic [15:0] a, input int budget, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (imem_req && imem_addr == a) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, 64'(found), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] a_t3, tgt;
  logic [1:0]  src;
  logic        jbit, found;
  int          d0;

  initial begin
    reset = 1'b0; stall = 1'b0; killF = 1'b0; PCSrc = 2'b00; PCsrcJType = 1'b0;
    branch_target = '0; for_target = '0; jump_target = '0; ret_addr = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    restart_model(16'h0000);
    #1;
    check("reset_valid", 64'(IFID_valid), 64'd0);
    check("reset_instr", 64'(IFID_instr), 64'(NOP));
    check("reset_pc", 64'({IFID_pc, IFID_pcplus}), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("req_low_after_release", 64'(imem_req), 64'd0);
    @(posedge clk); #1;
    check("first_req", 64'({imem_req, imem_addr}), 64'({1'b1, 16'h0000}));

    // streaming at one instruction per cycle
    @(negedge clk);
    @(negedge clk);
    d0 = n_deliv;
    repeat (8) @(negedge clk);
    check("stream_rate", 64'(n_deliv - d0), 64'd8);

    // stall on the cycle a fetch completes: parks in skid, req drops
    a_t3 = imem_addr;
    stall = 1'b1;
    @(posedge clk); #1;
    check("skid_req_low", 64'(imem_req), 64'd0);
    check("skid_state", 64'(state_dbg), 64'(ST_HOLD_DBG));
    check("skid_ifid_held", 64'(IFID_pc), 64'(a_t3 - 16'd1));
    repeat (2) @(negedge clk);
    stall = 1'b0;
    @(posedge clk); #1;
    check("skid_release", 64'({IFID_valid, IFID_instr, IFID_pc}), 64'({1'b1, mem_fn(a_t3), a_t3}));
    @(negedge clk);
    check("addr_after_skid", 64'({imem_req, imem_addr}), 64'({1'b1, a_t3 + 16'd1}));

    // reset in the middle of a fetch
    reset = 1'b0;
    #1;
    check("midreset_outputs", 64'({imem_req, IFID_valid, IFID_instr}), 64'({1'b0, 1'b0, NOP}));
    restart_model(16'h0000);
    lat_min = 2; lat_max = 2;
    @(negedge clk);
    reset = 1'b1;
    wait_addr(16'h0000, 4, "addr0_after_reset");

    // redirect during an outstanding slow fetch
    wait_addr(16'h0005, 40, "reach_addr5");
    do_redirect(2'b01, 1'b0, 16'h0040);
    #1;
    check("discard_state", 64'({state_dbg, imem_addr}), 64'({ST_DISCARD_DBG, 16'h0005}));
    check("discard_bubble", 64'(IFID_valid), 64'd0);
    wait_addr(16'h0040, 10, "branch_addr");

    // J-type redirects
    lat_min = 0; lat_max = 1;
    do_redirect(2'b11, 1'b1, 16'h0123);
    wait_addr(16'h0123, 10, "ret_addr");
    repeat (3) @(negedge clk);
    do_redirect(2'b11, 1'b0, 16'h0200);
    wait_addr(16'h0200, 10, "jump_addr");
    repeat (3) @(negedge clk);

    // wrap-around through FOR target
    lat_min = 0; lat_max = 0;
    do_redirect(2'b10, 1'b0, 16'hFFFE);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (IFID_valid && IFID_pc == 16'hFFFF) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_pc_ffff", 64'(found), 64'd1);
    check("wrap_pcplus", 64'(IFID_pcplus), 64'h0000);
    check("wrap_next_addr", 64'({imem_req, imem_addr}), 64'({1'b1, 16'h0000}));

    // killF under stall is ignored
    @(negedge clk);
    stall = 1'b1; killF = 1'b1; PCSrc = 2'b01; branch_target = 16'h0777;
    repeat (3) @(negedge clk);
    stall = 1'b0; killF = 1'b0; PCSrc = 2'b00;
    repeat (4) @(negedge clk);

    // randomized stalls, latencies and redirects
    lat_min = 0; lat_max = 3;
    for (int c = 0; c < 600; c++) begin
      branch_target = 16'($urandom);
      for_target    = 16'($urandom);
      jump_target   = 16'($urandom);
      ret_addr      = 16'($urandom);
      stall = ($urandom_range(0, 3) == 0);
      killF = 1'b0;
      PCSrc = 2'($urandom_range(0, 3));
      PCsrcJType = 1'($urandom_range(0, 1));
      if (!stall && $urandom_range(0, 11) == 0) begin
        src = 2'($urandom_range(1, 3));
        jbit = PCsrcJType;
        PCSrc = src;
        killF = 1'b1;
        tgt = (src == 2'b01) ? branch_target :
              (src == 2'b10) ? for_target :
              (jbit ? ret_addr : jump_target);
        restart_model(tgt);
      end else if (stall && $urandom_range(0, 3) == 0) begin
        killF = 1'b1;
      end
      @(negedge clk);
    end
    stall = 1'b0; killF = 1'b0; PCSrc = 2'b00;
    repeat (10) @(negedge clk);
    check("deliveries_seen", 64'(n_deliv > 150), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
